fp8_dot_acc: RTL and testbench
==============================

Name: fp8_dot_acc

Overview:
Parametrised successor to the single-pair FP8 MAC. Streams LEN operand pairs per operation over a valid/ready handshake and accumulates the products exactly in a wide fixed-point (Kulisch) accumulator. Rounds once to FP8 at the end and returns the result over a valid/ready output handshake. The accumulator can optionally carry over from the previous operation. Sits between the operand fetch logic and result writeback in the FP8 datapath.

Parameters:
EXP_W, 4, exponent bits; bias fixed at BIAS = 2^(EXP_W-1)-1 (7 by default).
MAN_W, 3, mantissa fraction bits; element width W = 1+EXP_W+MAN_W.
LEN_W, 8, width of the length field; max pairs per operation = 2^LEN_W-1.
Derived, not overridable: FRAC = 2*(BIAS-1)+2*MAN_W; INT = 2*(2^EXP_W-1-BIAS)+2; ACC_W = 1+LEN_W+INT+FRAC (45 at defaults).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin an operation; sampled only in IDLE
acc_keep  in  1  sampled with start: 1 = keep the accumulator, 0 = clear it
len  in  LEN_W  number of pairs, sampled with start
in_valid  in  1  operand pair valid
in_ready  out  1  pair accepted on a clk edge when in_valid && in_ready
a  in  W  FP8 operand {sign, exp, man}
b  in  W  FP8 operand
out_valid  out  1  result valid
out_ready  in  1  result consumed when out_valid && out_ready
acc_out  out  W  rounded FP8 result
sat  out  1  result was clamped to max finite; valid with out_valid
busy  out  1  state != IDLE

Behaviour:
- Reset, and any time rst_n is low including mid-operation: state = IDLE; in_ready, out_valid, sat, busy = 0; acc_out = 0; accumulator, product register and counter = 0.
- FSM states: IDLE, ACCUM, DRAIN, NORM, DONE.
- IDLE: in_ready = 0. On start, latch len into the counter; clear the accumulator if acc_keep = 0. If len = 0, go to NORM; otherwise go to ACCUM.
- ACCUM: in_ready = 1.
  - Each accepted pair: exact signed product registered in the product register; counter decrements.
  - The product register is added into the accumulator on the next edge.
  - When the accepted pair brings the counter to 0, go to DRAIN. in_ready drops on that same edge.
- DRAIN: the final product is added into the accumulator; go to NORM.
- NORM: leading-one detect on |acc|; round-to-nearest-even to MAN_W bits; register acc_out and sat; go to DONE.
- DONE: out_valid = 1. acc_out and sat are held stable until out_ready, then go to IDLE.
- start is ignored outside IDLE.
- Latency: last pair accepted at edge k gives out_valid high after edge k+2. With len = 0, out_valid is high 2 edges after start.
- in_valid gaps are allowed; the counter only moves on accepted pairs.
- Input decode:
  - exp = 0 means zero; the mantissa is ignored (flush-to-zero).
  - exp all-ones is an ordinary normal number; there is no Inf or NaN.
- Product: (1.ma * 1.mb) * 2^(ea+eb-2*BIAS), placed exactly at fixed-point LSB weight 2^-FRAC.
- Accumulator: two's complement, ACC_W bits. The add saturates at the ACC_W range limits; it never wraps.
- Output conversion:
  - Zero result gives 0x00.
  - |result| < 2^(1-BIAS) after rounding gives 0x00.
  - |result| > max finite (exp all-ones, man all-ones; 480.0 at defaults) gives sign|max finite with sat = 1.
  - Rounding carry-out increments the exponent; if that overflows, the saturation rule applies.

Optional Feature:
Macro FP8_DOT_SUBNORM_EN.
- Defined: inputs with exp = 0 are subnormal, 0.m * 2^(1-BIAS). FRAC grows by 2*MAN_W. Outputs below 2^(1-BIAS) round RNE to subnormal encodings instead of flushing.
- Not defined: flush-to-zero on inputs and outputs as in Behaviour.

Test Plan:
1. acc_keep=0, len=3, pairs (0x38,0x40), (0x44,0x30), (0x48,0x48), i.e. 2+1.5+16 = 19.5 -> acc_out 0x5A (20.0), sat=0; out_valid 2 edges after the third accept.
2. Immediately after test 1: acc_keep=1, len=1, pair (0xC2 = -2.5, 0x48 = 4.0) -> exact 9.5, RNE tie -> acc_out 0x52 (10.0). Same pair with acc_keep=0 -> 0xD2 (-10.0).
3. len=0, acc_keep=0 -> in_ready never high; acc_out 0x00 after 2 edges. Then len=1, pair (0x08,0x08) = 2^-12 -> underflow flush 0x00.
4. len=2, pairs (0x7F,0x7F) twice -> acc_out 0x7F, sat=1. Negated first operand (0xFF) -> 0xFF, sat=1.
5. len=3 with in_valid low for 2 cycles between pairs; out_ready held low 5 cycles; start pulsed during DONE -> acc_out and out_valid stable, start ignored; after out_ready=1 -> IDLE next edge, busy=0.
6. Assert rst_n low after 1 of 3 pairs -> all outputs 0 at once. A following op with acc_keep=1, len=1, pair (0x38,0x38) -> 0x38.

Source files
------------

// File: rtl/fp8_dot_acc.sv
// FP8 dot-product engine: streams LEN operand pairs, accumulates products exactly in a
// Kulisch accumulator and rounds once to FP8. Define FP8_DOT_SUBNORM_EN for subnormal support.
module fp8_dot_acc #(
  parameter int unsigned EXP_W = 4,
  parameter int unsigned MAN_W = 3,
  parameter int unsigned LEN_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       acc_keep,
  input  logic [LEN_W-1:0]           len,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [EXP_W+MAN_W:0]       a,
  input  logic [EXP_W+MAN_W:0]       b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [EXP_W+MAN_W:0]       acc_out,
  output logic                       sat,
  output logic                       busy
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int EMAX = (1 << EXP_W) - 1;
`ifdef FP8_DOT_SUBNORM_EN
  localparam int SUB_SH = 2 * MAN_W;
  // Bit of |acc| weighing one subnormal ULP, 2^(1-BIAS-MAN_W)
  localparam int SQ = 2 * (BIAS - 1) + 4 * MAN_W + 1 - BIAS - MAN_W;
`else
  localparam int SUB_SH = 0;
`endif
  localparam int FRAC  = 2 * (BIAS - 1) + 2 * MAN_W + SUB_SH;
  localparam int INT_W = 2 * (EMAX - BIAS) + 2;
  localparam int ACC_W = 1 + LEN_W + INT_W + FRAC;
  localparam int MP_W  = 2 * (MAN_W + 1);

  typedef enum logic [2:0] {StIdle, StAccum, StDrain, StNorm, StDone} state_e;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  prod_q, prod_d;
  logic [W-1:0]      out_q, out_d;
  logic              sat_q, sat_d;

  // Exact signed product of the current operand pair
  logic [EXP_W-1:0]  ea, eb, ea_eff, eb_eff;
  logic [MAN_W:0]    siga, sigb;
  logic [MP_W-1:0]   mp;
  logic [ACC_W-1:0]  pmag, pval;
  int                sh;

  always_comb begin
    ea     = a[W-2 -: EXP_W];
    eb     = b[W-2 -: EXP_W];
    ea_eff = (ea == '0) ? EXP_W'(1) : ea;
    eb_eff = (eb == '0) ? EXP_W'(1) : eb;
`ifdef FP8_DOT_SUBNORM_EN
    siga   = {|ea, a[MAN_W-1:0]};
    sigb   = {|eb, b[MAN_W-1:0]};
`else
    siga   = (ea == '0) ? '0 : {1'b1, a[MAN_W-1:0]};
    sigb   = (eb == '0) ? '0 : {1'b1, b[MAN_W-1:0]};
`endif
    mp     = MP_W'(siga) * MP_W'(sigb);
    sh     = int'(ea_eff) + int'(eb_eff) - 2 + SUB_SH;
    pmag   = ACC_W'(mp) << sh;
    pval   = (a[W-1] ^ b[W-1]) ? (~pmag + ACC_W'(1)) : pmag;
  end

  // Saturating accumulate
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] acc_sum;

  always_comb begin
    sum = {acc_q[ACC_W-1], acc_q} + {prod_q[ACC_W-1], prod_q};
    if (sum[ACC_W] != sum[ACC_W-1]) begin
      acc_sum = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      acc_sum = sum[ACC_W-1:0];
    end
  end

  // Normalise |acc| and round to nearest even
  logic [ACC_W-1:0] mag;
  logic [ACC_W-2:0] nrm;
  logic [MAN_W:0]   rnd;
  logic             guard, sticky, rup, res_sign, res_sat;
  logic [W-1:0]     res;
  int               lzp, e_pre, e_b;
`ifdef FP8_DOT_SUBNORM_EN
  logic [MAN_W:0]   sub_r;
`endif

  always_comb begin
    res_sign = acc_q[ACC_W-1];
    mag      = res_sign ? (~acc_q + ACC_W'(1)) : acc_q;
    lzp      = 0;
    for (int i = 0; i < ACC_W; i++) begin
      if (mag[i]) lzp = i;
    end
    nrm    = (ACC_W-1)'(mag << (ACC_W - 1 - lzp));
    guard  = nrm[ACC_W-2-MAN_W];
    sticky = |nrm[ACC_W-3-MAN_W:0];
    rup    = guard & (sticky | nrm[ACC_W-1-MAN_W]);
    rnd    = {1'b0, nrm[ACC_W-2 -: MAN_W]} + (MAN_W+1)'(rup);
    e_pre  = lzp - FRAC + BIAS;
    e_b    = e_pre + int'(rnd[MAN_W]);
`ifdef FP8_DOT_SUBNORM_EN
    sub_r  = {1'b0, mag[SQ+MAN_W-1:SQ]}
           + (MAN_W+1)'(mag[SQ-1] & ((|mag[SQ-2:0]) | mag[SQ]));
`endif
    res     = '0;
    res_sat = 1'b0;
    if (mag == '0) begin
      res = '0;
    end else if (e_b > EMAX) begin
      res     = {res_sign, {(W-1){1'b1}}};
      res_sat = 1'b1;
`ifdef FP8_DOT_SUBNORM_EN
    end else if (e_pre < 1) begin
      // A carry out of the subnormal mantissa lands in the exponent LSB
      res = (sub_r == '0) ? '0 : {res_sign, (EXP_W+MAN_W)'(sub_r)};
`endif
    end else if (e_b >= 1) begin
      res = {res_sign, EXP_W'(e_b), rnd[MAN_W-1:0]};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    out_d   = out_q;
    sat_d   = sat_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          cnt_d = len;
          if (!acc_keep) acc_d = '0;
          state_d = (len == '0) ? StNorm : StAccum;
        end
      end
      StAccum: begin
        acc_d  = acc_sum;
        prod_d = '0;
        if (in_valid) begin
          prod_d = pval;
          cnt_d  = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) state_d = StDrain;
        end
      end
      StDrain: begin
        acc_d   = acc_sum;
        prod_d  = '0;
        state_d = StNorm;
      end
      StNorm: begin
        out_d   = res;
        sat_d   = res_sat;
        state_d = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
      out_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
      out_q   <= out_d;
      sat_q   <= sat_d;
    end
  end

  assign in_ready  = (state_q == StAccum);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign acc_out   = out_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_fp8_dot_acc.sv
// Scoreboard bench for fp8_dot_acc: expected results queued at stimulus time, popped on output.
module tb_fp8_dot_acc;

  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic             acc_keep = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       a = '0;
  logic [7:0]       b = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [7:0]       acc_out;
  logic             sat;
  logic             busy;

  fp8_dot_acc dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .acc_keep  (acc_keep),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc_out   (acc_out),
    .sat       (sat),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  real        acc_m = 0.0;
  logic [8:0] exp_q[$];  // {sat, acc_out}

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic real fp8_val(input logic [7:0] x);
    int  e;
    real v;
    e = int'(x[6:3]);
    if (e == 0) return 0.0;
    v = real'(8 + int'(x[2:0]));
    for (int i = 0; i < e; i++) v = v * 2.0;
    v = v / 1024.0;
    return x[7] ? -v : v;
  endfunction

  function automatic logic [8:0] to_fp8(input real v);
    real  mag, fl, rem;
    int   e;
    logic s;
    if (v == 0.0) return 9'h000;
    s   = (v < 0.0);
    mag = s ? -v : v;
    e   = 0;
    for (int i = 0; i < 200 && mag >= 2.0; i++) begin mag = mag / 2.0; e++; end
    for (int i = 0; i < 200 && mag < 1.0; i++) begin mag = mag * 2.0; e--; end
    fl  = $floor((mag - 1.0) * 8.0);
    rem = (mag - 1.0) * 8.0 - fl;
    if (rem > 0.5 || (rem == 0.5 && ($rtoi(fl) % 2) == 1)) fl = fl + 1.0;
    if (fl >= 8.0) begin fl = 0.0; e++; end
    if (e + 7 > 15) return {1'b1, s, 7'h7F};
    if (e + 7 < 1) return 9'h000;
    return {1'b0, s, 4'(e + 7), 3'($rtoi(fl))};
  endfunction

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      check("q_nonempty", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        logic [8:0] e;
        e = exp_q.pop_front();
        check("acc_out", acc_out, e[7:0]);
        check("sat", sat, e[8]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic keep, input int n);
    start    = 1'b1;
    acc_keep = keep;
    len      = LEN_W'(n);
    step();
    start = 1'b0;
    if (!keep) acc_m = 0.0;
  endtask

  task automatic send_pair(input logic [7:0] pa, input logic [7:0] pb, input int gap);
    int t;
    repeat (gap) step();
    a        = pa;
    b        = pb;
    in_valid = 1'b1;
    t        = 0;
    while (!in_ready && t < 20) begin step(); t++; end
    check("in_ready_wait", 32'(t < 20), 1);
    step();
    in_valid = 1'b0;
    acc_m    = acc_m + fp8_val(pa) * fp8_val(pb);
  endtask

  task automatic drain();
    int t;
    t         = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && t < 20) begin step(); t++; end
    check("drain_wait", 32'(t < 20), 1);
    out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 rst_n = 1'b0;
    step();
    step();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_acc_out", acc_out, 0);
    check("rst_sat", sat, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // 1: 2 + 1.5 + 16 = 19.5 -> 20.0, two-edge latency after last accept
    start_op(1'b0, 3);
    send_pair(8'h38, 8'h40, 0);
    send_pair(8'h44, 8'h30, 0);
    send_pair(8'h48, 8'h48, 0);
    exp_q.push_back(9'h05A);
    check("t1_in_ready_drop", in_ready, 0);
    check("t1_ov_k", out_valid, 0);
    step();
    check("t1_ov_k1", out_valid, 0);
    step();
    check("t1_ov_k2", out_valid, 1);
    drain();

    // 2: keep 19.5, add -10 -> 9.5 ties to 10.0; then cleared -> -10.0
    start_op(1'b1, 1);
    send_pair(8'hC2, 8'h48, 0);
    exp_q.push_back(9'h052);
    drain();
    start_op(1'b0, 1);
    send_pair(8'hC2, 8'h48, 0);
    exp_q.push_back(9'h0D2);
    drain();

    // 3: zero-length op, then underflow flush
    start    = 1'b1;
    acc_keep = 1'b0;
    len      = '0;
    check("t3_ir_pre", in_ready, 0);
    step();
    start = 1'b0;
    acc_m = 0.0;
    check("t3_ir_s", in_ready, 0);
    check("t3_ov_s", out_valid, 0);
    step();
    check("t3_ir_s1", in_ready, 0);
    check("t3_ov_s1", out_valid, 1);
    exp_q.push_back(9'h000);
    drain();
    start_op(1'b0, 1);
    send_pair(8'h08, 8'h08, 0);
    exp_q.push_back(9'h000);
    drain();

    // 4: saturation, both signs
    start_op(1'b0, 2);
    send_pair(8'h7F, 8'h7F, 0);
    send_pair(8'h7F, 8'h7F, 0);
    exp_q.push_back(9'h17F);
    drain();
    start_op(1'b0, 2);
    send_pair(8'hFF, 8'h7F, 0);
    send_pair(8'hFF, 8'h7F, 0);
    exp_q.push_back(9'h1FF);
    drain();

    // 5: input gaps, output back-pressure, start ignored in DONE (3 + 2.25 - 1.25 = 4.0)
    start_op(1'b0, 3);
    send_pair(8'h3C, 8'h40, 0);
    send_pair(8'h34, 8'h44, 2);
    send_pair(8'hB8, 8'h3A, 2);
    exp_q.push_back(to_fp8(acc_m));
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      start    = (i == 2);
      acc_keep = 1'b0;
      len      = LEN_W'(1);
      check("t5_ov_hold", out_valid, 1);
      check("t5_out_hold", acc_out, 8'h48);
      check("t5_busy_hold", busy, 1);
      step();
    end
    start = 1'b0;
    drain();
    check("t5_busy_idle", busy, 0);
    check("t5_ov_idle", out_valid, 0);
    step();
    check("t5_ir_idle", in_ready, 0);
    check("t5_busy_stay", busy, 0);

    // 6: reset mid-operation clears everything, keep starts from zero
    start_op(1'b0, 3);
    send_pair(8'h38, 8'h38, 0);
    rst_n = 1'b0;
    #1;
    check("t6_in_ready", in_ready, 0);
    check("t6_out_valid", out_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_acc_out", acc_out, 0);
    check("t6_sat", sat, 0);
    acc_m = 0.0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    start_op(1'b1, 1);
    send_pair(8'h38, 8'h38, 0);
    exp_q.push_back(9'h038);
    drain();

    check("q_empty_end", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
